regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-read-port register file with write-through bypass and a per-register busy scoreboard.
//  It is the next-generation integer register file for the pipelined ARM datapath: decode reads operands here,
//  writeback writes results here, and issue marks pending destinations so hazard logic can stall on busy operands.
//  One register is hard-wired to zero (XZR).
// PARAMETERS
//  N        64  data width in bits
//  NREG     32  number of architectural registers (power of 2, >= 4)
//  NRD      2   number of read ports
//  ZREG     31  index of the hard-wired zero register (0 <= ZREG < NREG)
//  BYPASS   1   1 = same-cycle write-through to read ports; 0 = reads see stored value only
// PORTS  (AW = $clog2(NREG))
//  clk         in   1         clock; all state updates on posedge
//  reset       in   1         synchronous, active-high reset
//  ra          in   NRD*AW    read addresses; port k = ra[k*AW +: AW]
//  rd          out  NRD*N     read data; port k = rd[k*N +: N]
//  rbusy       out  NRD       port k operand still pending (scoreboard), after bypass
//  we3         in   1         writeback enable
//  wa3         in   AW        writeback address
//  wd3         in   N         writeback data
//  iss_valid   in   1         issue of an instruction with a destination register
//  iss_wa      in   AW        destination of issued instruction
//  any_busy    out  1         OR of all scoreboard bits (drain/flush status)
// BEHAVIOUR
//  Reset (clk edge with reset=1): reg[i] <= i for i != ZREG, reg[ZREG] <= 0; all busy bits <= 0.
//   Outputs are combinational from state, so after reset rd[k] = ra[k] (0 for ZREG), rbusy = 0, any_busy = 0.
//   reset overrides we3 and iss_valid in the same cycle; writes/issues presented with reset are dropped.
//  Reads: combinational, zero latency. For each port k independently:
//   ra[k] == ZREG                                  -> rd = 0, rbusy = 0 (always).
//   BYPASS && we3 && wa3 == ra[k] && wa3 != ZREG   -> rd = wd3, rbusy = 0.
//   otherwise                                      -> rd = reg[ra[k]], rbusy = busy[ra[k]].
//   The bypass compare is gated on we3; a matching wa3 with we3 = 0 does NOT forward.
//  Write: at posedge, if we3 && wa3 != ZREG: reg[wa3] <= wd3. Writes to ZREG are discarded silently.
//   A write to a non-busy register is legal and updates normally.
//  Scoreboard (one bit per register, busy[ZREG] tied 0):
//   set   : iss_valid && iss_wa != ZREG  -> busy[iss_wa] <= 1 at posedge.
//   clear : we3 && wa3 != ZREG           -> busy[wa3] <= 0 at posedge.
//   Set and clear on the same register in the same cycle: set wins (new producer supersedes retiring one).
//   Set and clear on different registers in the same cycle: both take effect.
//   Issue to an already-busy register: stays busy (single bit, no counting; in-order pipeline).
//   Set is visible on rbusy from the cycle after issue; no same-cycle issue->rbusy forwarding.
//  any_busy = |busy, registered-state only (no bypass term).
//  Widths: no arithmetic; addresses >= NREG (non-power-of-2 never allowed) are out of scope.
// STRUCTURE
//  Package regfile_pkg: localparam XZR = 31, function reg_reset_val(idx, N) returning idx (0 for XZR),
//   typedef logic [$clog2(32)-1:0] reg_addr_t for the 32-register configuration.
//  Sub-module reg_scoreboard (clk, reset, set_en, set_idx, clr_en, clr_idx, busy[NREG-1:0]) holds the busy
//   vector and the set-wins priority; regfile_sb instantiates it and owns storage, bypass and read muxing.
//  Read ports generated with a generate-for over NRD; no latch inference; storage is one always_ff.
// TESTING
//  1 reset; then read ra={3,31} -> rd={3,0}, rbusy=00, any_busy=0.
//  2 we3=1 wa3=5 wd3=64'hDEAD_BEEF, ra0=5 same cycle -> rd0=DEAD_BEEF (bypass); BYPASS=0 build -> rd0=5 until next cycle.
//  3 we3=0 wa3=7 wd3=64'h1234, ra0=7 -> rd0=7 (no forward); next cycle reg[7] still 7.
//  4 iss 9; next cycle ra0=9 -> rbusy0=1, any_busy=1; we3 wa3=9 wd3=42 -> same cycle rd0=42 rbusy0=0; next cycle busy[9]=0.
//  5 same cycle iss_wa=4 and we3 wa3=4 -> busy[4]=1 after edge; write 31 with 64'hFFFF -> rd(31)=0, busy[31]=0.
//  6 issue 2 and 3, assert reset mid-operation with we3 wa3=2 -> after edge reg[2]=2, all busy=0, any_busy=0.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants, types and helpers for the integer
//                register file. XZR is the architectural zero register.
//                reg_reset_val() gives each register's reset value: its own
//                index, or 0 for XZR.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XZR = 31;

    typedef logic [$clog2(32)-1:0] reg_addr_t;

    // Reset value for register idx in an n-bit-wide file. Registers reset to
    // their own index so software can spot uninitialised reads; XZR is 0.
    function automatic logic [63:0] reg_reset_val(input int unsigned idx,
                                                  input int unsigned n);
        logic [63:0] v;
        v = 64'(idx);
        if (idx == XZR) begin
            v = '0;
        end
        if (n < 64) begin
            v = v & ((64'd1 << n) - 64'd1);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : One busy bit per architectural register. Issue sets the
//                destination's bit, writeback clears it. When both hit the
//                same register in one cycle, the set wins: the newly issued
//                producer supersedes the one retiring.
//  Ports       : clk, reset (sync, active-high)
//                set_en/set_idx : mark a register pending
//                clr_en/clr_idx : mark a register complete
//                busy           : current busy vector (ZREG always 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int ZREG = XZR,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en,
    input  logic [AW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_idx,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] r_busy;

    // The set is written after the clear so that, on a collision, the later
    // non-blocking assignment (set) takes effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (clr_en) begin
                r_busy[clr_idx] <= 1'b0;
            end
            if (set_en) begin
                r_busy[set_idx] <= 1'b1;
            end
        end
    end

    // The zero register can never be pending, whatever the callers do.
    always_comb begin
        busy       = r_busy;
        busy[ZREG] = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Multi-read-port integer register file with write-through
//                bypass and a per-register busy scoreboard. Register ZREG
//                reads as zero and ignores writes.
//  Ports       : clk, reset          clock / sync active-high reset
//                ra[NRD*AW]          read addresses, port k at k*AW
//                rd[NRD*N]           read data, port k at k*N
//                rbusy[NRD]          per-port operand pending (after bypass)
//                we3, wa3, wd3       writeback port
//                iss_valid, iss_wa   issue of an instruction with a dest reg
//                any_busy            OR of all busy bits (no bypass term)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int N      = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int ZREG   = XZR,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*N-1:0]  rd,
    output logic [NRD-1:0]    rbusy,
    input  logic              we3,
    input  logic [AW-1:0]     wa3,
    input  logic [N-1:0]      wd3,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_wa,
    output logic              any_busy
);

    localparam logic [AW-1:0] c_ZADDR = AW'(ZREG);

    logic [N-1:0]    r_regs [NREG];
    logic [NREG-1:0] w_busy;
    logic            w_wr_en;
    logic            w_iss_en;

    // Writes and issues that target the zero register are dropped here, so
    // neither storage nor scoreboard ever sees them.
    assign w_wr_en  = we3 && (wa3 != c_ZADDR);
    assign w_iss_en = iss_valid && (iss_wa != c_ZADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= (i == ZREG) ? '0 : N'(reg_reset_val(i, N));
            end
        end else if (w_wr_en) begin
            r_regs[wa3] <= wd3;
        end
    end

    reg_scoreboard #(
        .NREG (NREG),
        .ZREG (ZREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (w_iss_en),
        .set_idx (iss_wa),
        .clr_en  (w_wr_en),
        .clr_idx (wa3),
        .busy    (w_busy)
    );

    assign any_busy = |w_busy;

    // Each read port resolves independently: zero register first, then the
    // in-flight writeback (if bypass is built in), then stored state.
    for (genvar k = 0; k < NRD; k++) begin : g_rdport
        logic [AW-1:0] w_ra;
        logic [N-1:0]  w_rd;
        logic          w_rbusy;

        assign w_ra = ra[k*AW +: AW];

        always_comb begin
            w_rd    = r_regs[w_ra];
            w_rbusy = w_busy[w_ra];
            if (w_ra == c_ZADDR) begin
                w_rd    = '0;
                w_rbusy = 1'b0;
            end else if ((BYPASS != 0) && we3 && (wa3 == w_ra)) begin
                w_rd    = wd3;
                w_rbusy = 1'b0;
            end
        end

        assign rd[k*N +: N] = w_rd;
        assign rbusy[k]     = w_rbusy;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Directed self-checking bench for regfile_sb in its default
//                configuration (64-bit, 32 regs, 2 read ports, XZR=31,
//                bypass on). Inputs change 1 time unit after posedge and
//                outputs are sampled 1 unit after that.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int c_N   = 64;
    localparam int c_AW  = 5;
    localparam int c_NRD = 2;

    logic                  clk;
    logic                  r_reset;
    logic [c_NRD*c_AW-1:0] r_ra;
    logic [c_NRD*c_N-1:0]  w_rd;
    logic [c_NRD-1:0]      w_rbusy;
    logic                  r_we3;
    logic [c_AW-1:0]       r_wa3;
    logic [c_N-1:0]        r_wd3;
    logic                  r_iss_valid;
    logic [c_AW-1:0]       r_iss_wa;
    logic                  w_any_busy;

    int n_vec;
    int n_err;

    regfile_sb #(
        .N      (64),
        .NREG   (32),
        .NRD    (2),
        .ZREG   (31),
        .BYPASS (1)
    ) dut (
        .clk       (clk),
        .reset     (r_reset),
        .ra        (r_ra),
        .rd        (w_rd),
        .rbusy     (w_rbusy),
        .we3       (r_we3),
        .wa3       (r_wa3),
        .wd3       (r_wd3),
        .iss_valid (r_iss_valid),
        .iss_wa    (r_iss_wa),
        .any_busy  (w_any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        r_ra = {a1, a0};
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        r_reset     = 1'b1;
        r_ra        = '0;
        r_we3       = 1'b0;
        r_wa3       = '0;
        r_wd3       = '0;
        r_iss_valid = 1'b0;
        r_iss_wa    = '0;
        step();
        r_reset = 1'b0;

        // 1: reset state
        set_ra(5'd3, 5'd31);
        #1;
        chk("rst_rd0",   w_rd[63:0],   64'd3);
        chk("rst_rd1",   w_rd[127:64], 64'd0);
        chk("rst_rbusy", {62'd0, w_rbusy}, 64'd0);
        chk("rst_any",   {63'd0, w_any_busy}, 64'd0);

        // 2: same-cycle bypass on port 0; port 1 unaffected
        r_we3 = 1'b1; r_wa3 = 5'd5; r_wd3 = 64'hDEAD_BEEF;
        set_ra(5'd5, 5'd6);
        #1;
        chk("byp_rd0", w_rd[63:0],   64'hDEAD_BEEF);
        chk("byp_rd1", w_rd[127:64], 64'd6);
        step();
        r_we3 = 1'b0;
        #1;
        chk("wr_stored", w_rd[63:0], 64'hDEAD_BEEF);

        // 3: matching address with we3=0 must not forward or write
        r_wa3 = 5'd7; r_wd3 = 64'h1234;
        set_ra(5'd7, 5'd5);
        #1;
        chk("nofwd_rd0", w_rd[63:0], 64'd7);
        step();
        chk("nowr_rd0", w_rd[63:0], 64'd7);

        // 4: issue 9, no same-cycle rbusy, then busy next cycle
        r_iss_valid = 1'b1; r_iss_wa = 5'd9;
        set_ra(5'd9, 5'd9);
        #1;
        chk("iss_same_rbusy", {63'd0, w_rbusy[0]}, 64'd0);
        chk("iss_same_any",   {63'd0, w_any_busy}, 64'd0);
        step();
        r_iss_valid = 1'b0;
        #1;
        chk("iss_rbusy0", {63'd0, w_rbusy[0]}, 64'd1);
        chk("iss_rbusy1", {63'd0, w_rbusy[1]}, 64'd1);
        chk("iss_any",    {63'd0, w_any_busy}, 64'd1);
        chk("iss_rd0",    w_rd[63:0], 64'd9);
        // writeback clears with bypass in the same cycle
        r_we3 = 1'b1; r_wa3 = 5'd9; r_wd3 = 64'd42;
        #1;
        chk("wb_rd0",    w_rd[63:0], 64'd42);
        chk("wb_rbusy0", {63'd0, w_rbusy[0]}, 64'd0);
        chk("wb_any",    {63'd0, w_any_busy}, 64'd1);
        step();
        r_we3 = 1'b0;
        #1;
        chk("clr_rbusy0", {63'd0, w_rbusy[0]}, 64'd0);
        chk("clr_rd0",    w_rd[63:0], 64'd42);
        chk("clr_any",    {63'd0, w_any_busy}, 64'd0);

        // 5: issue and writeback same register same cycle -> set wins
        r_iss_valid = 1'b1; r_iss_wa = 5'd4;
        r_we3 = 1'b1; r_wa3 = 5'd4; r_wd3 = 64'd77;
        set_ra(5'd4, 5'd6);
        #1;
        chk("col_byp_rd0",   w_rd[63:0], 64'd77);
        chk("col_byp_rbusy", {63'd0, w_rbusy[0]}, 64'd0);
        step();
        r_iss_valid = 1'b0; r_we3 = 1'b0;
        #1;
        chk("col_rbusy0", {63'd0, w_rbusy[0]}, 64'd1);
        chk("col_rd0",    w_rd[63:0], 64'd77);
        chk("col_any",    {63'd0, w_any_busy}, 64'd1);

        // different registers same cycle: clear 4, set 6
        r_iss_valid = 1'b1; r_iss_wa = 5'd6;
        r_we3 = 1'b1; r_wa3 = 5'd4; r_wd3 = 64'd88;
        step();
        r_iss_valid = 1'b0; r_we3 = 1'b0;
        #1;
        chk("diff_rbusy0", {63'd0, w_rbusy[0]}, 64'd0);
        chk("diff_rd0",    w_rd[63:0], 64'd88);
        chk("diff_rbusy1", {63'd0, w_rbusy[1]}, 64'd1);
        chk("diff_rd1",    w_rd[127:64], 64'd6);

        // writes/issues to XZR are discarded
        r_iss_valid = 1'b1; r_iss_wa = 5'd31;
        r_we3 = 1'b1; r_wa3 = 5'd31; r_wd3 = 64'hFFFF;
        set_ra(5'd31, 5'd6);
        #1;
        chk("z_byp_rd0",   w_rd[63:0], 64'd0);
        chk("z_byp_rbusy", {63'd0, w_rbusy[0]}, 64'd0);
        step();
        r_iss_valid = 1'b0; r_we3 = 1'b0;
        #1;
        chk("z_rd0",    w_rd[63:0], 64'd0);
        chk("z_rbusy0", {63'd0, w_rbusy[0]}, 64'd0);
        chk("z_rbusy1", {63'd0, w_rbusy[1]}, 64'd1);

        // re-issue to an already-busy register stays busy
        r_iss_valid = 1'b1; r_iss_wa = 5'd6;
        step();
        r_iss_valid = 1'b0;
        #1;
        chk("reiss_rbusy1", {63'd0, w_rbusy[1]}, 64'd1);

        // 6: issue 2 and 3, then reset with a write/issue pending
        r_iss_valid = 1'b1; r_iss_wa = 5'd2;
        step();
        r_iss_wa = 5'd3;
        step();
        r_iss_valid = 1'b0;
        set_ra(5'd2, 5'd3);
        #1;
        chk("pre_rst_rbusy", {62'd0, w_rbusy}, 64'd3);
        r_reset = 1'b1;
        r_we3 = 1'b1; r_wa3 = 5'd2; r_wd3 = 64'd555;
        r_iss_valid = 1'b1; r_iss_wa = 5'd8;
        step();
        r_reset = 1'b0; r_we3 = 1'b0; r_iss_valid = 1'b0;
        #1;
        chk("mrst_rd0",   w_rd[63:0],   64'd2);
        chk("mrst_rd1",   w_rd[127:64], 64'd3);
        chk("mrst_rbusy", {62'd0, w_rbusy}, 64'd0);
        chk("mrst_any",   {63'd0, w_any_busy}, 64'd0);
        set_ra(5'd5, 5'd8);
        #1;
        chk("mrst_r5",  w_rd[63:0],   64'd5);
        chk("mrst_r8",  w_rd[127:64], 64'd8);
        chk("mrst_b8",  {63'd0, w_rbusy[1]}, 64'd0);
        set_ra(5'd4, 5'd9);
        #1;
        chk("mrst_r4",  w_rd[63:0],   64'd4);
        chk("mrst_r9",  w_rd[127:64], 64'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
